// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory port bundle shared by mem_arbiter and its environment
interface mem_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_valid, i_addr,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        input  mem_ready, mem_rdata,
        output i_ready, i_rdata,
        output d_ready, d_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output i_valid, i_addr,
        output d_valid, d_addr, d_wdata, d_wstrb,
        output mem_ready, mem_rdata,
        input  i_ready, i_rdata,
        input  d_ready, d_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter for the single memory port (optional MEM_ARBITER_ROUND_ROBIN_EN)
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          bus_err,
    output logic          busy
);

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    owner_t           owner_q;
    owner_t           last_grant_q, last_grant_d;
    owner_t           winner;
    logic             abandoned_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic req_any;
    logic owner_valid;
    logic timeout_hit;
    logic complete;
    logic owner_ack;

    // Pick the winner of the next grant.
    always_comb begin
        req_any = bus.i_valid | bus.d_valid;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        // On a tie, favour whoever was not granted last.
        winner = (bus.d_valid && (!bus.i_valid || last_grant_q == OWN_I)) ? OWN_D : OWN_I;
`else
        winner = bus.d_valid ? OWN_D : OWN_I;
`endif
    end

    // Completion, timeout and owner response qualification.
    always_comb begin
        owner_valid = (owner_q == OWN_D) ? bus.d_valid : bus.i_valid;
        timeout_hit = (TIMEOUT != 0) && (state_q == ISSUE) && !bus.mem_ready && (cnt_q == TIMEOUT_C);
        complete    = (state_q == ISSUE) && (bus.mem_ready || timeout_hit);
        owner_ack   = complete && owner_valid && !abandoned_q;
    end

    // Response routing; a timed-out completion returns zero data.
    always_comb begin
        bus.i_ready = owner_ack && (owner_q == OWN_I);
        bus.d_ready = owner_ack && (owner_q == OWN_D);
        bus.i_rdata = (bus.i_ready && bus.mem_ready) ? bus.mem_rdata : 32'h0;
        bus.d_rdata = (bus.d_ready && bus.mem_ready) ? bus.mem_rdata : 32'h0;
        bus_err     = timeout_hit;
    end

    // Memory-side outputs come straight from registered state.
    always_comb begin
        bus.mem_valid = (state_q == ISSUE);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = wstrb_q;
        busy          = (state_q == ISSUE);
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d      = ISSUE;
                    last_grant_d = winner;
                end
            end
            ISSUE: begin
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Request latch, abandon flag and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_I;
            abandoned_q <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
        end else if (state_q == IDLE) begin
            if (req_any) begin
                owner_q     <= winner;
                abandoned_q <= 1'b0;
                cnt_q       <= '0;
                if (winner == OWN_D) begin
                    addr_q  <= bus.d_addr;
                    wdata_q <= bus.d_wdata;
                    wstrb_q <= bus.d_wstrb;
                end else begin
                    // Fetches are always reads with no write payload.
                    addr_q  <= bus.i_addr;
                    wdata_q <= 32'h0;
                    wstrb_q <= 4'h0;
                end
            end
        end else begin
            // A dropped request stays dropped until the memory side finishes.
            if (!owner_valid) begin
                abandoned_q <= 1'b1;
            end
            if ((TIMEOUT != 0) && !bus.mem_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic rst;
    logic bus_err;
    logic busy;

    int n_checks;
    int n_fail;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .bus_err (bus_err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_valid   = 1'b0;
        bus.i_addr    = 32'h0;
        bus.d_valid   = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.d_wstrb   = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        exp_d;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        idle_inputs();

        // Reset state
        #1;
        check("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'h0);
        check("rst_ready", {30'b0, bus.i_ready, bus.d_ready}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);

        @(negedge clk);
        rst = 1'b1;

        // mem_ready while idle is ignored
        bus.mem_ready = 1'b1;
        #1;
        check("idle_ready_ign", {30'b0, bus.i_ready, bus.d_ready}, 32'd0);
        @(negedge clk);
        check("idle_ready_busy", {31'b0, busy}, 32'd0);
        bus.mem_ready = 1'b0;

        // Single load
        bus.d_valid = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wstrb = 4'h0;
        @(negedge clk);
        check("ld_mem_valid", {31'b0, bus.mem_valid}, 32'd1);
        check("ld_mem_addr", bus.mem_addr, 32'h100);
        check("ld_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'h0);
        check("ld_d_ready_wait", {31'b0, bus.d_ready}, 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_d_ready", {31'b0, bus.d_ready}, 32'd1);
        check("ld_d_rdata", bus.d_rdata, 32'hDEADBEEF);
        check("ld_i_ready", {31'b0, bus.i_ready}, 32'd0);
        @(negedge clk);
        bus.d_valid   = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("ld_done_d_ready", {31'b0, bus.d_ready}, 32'd0);
        check("ld_done_rdata", bus.d_rdata, 32'h0);
        check("ld_done_busy", {31'b0, busy}, 32'd0);

        // Store held over a three-cycle wait; inputs change after the latch
        bus.d_valid = 1'b1;
        bus.d_addr  = 32'h204;
        bus.d_wdata = 32'h11223344;
        bus.d_wstrb = 4'b1100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.d_addr  = 32'hFFFF0000;
            bus.d_wdata = 32'h0;
            bus.d_wstrb = 4'h0;
            #1;
            check("st_mem_valid", {31'b0, bus.mem_valid}, 32'd1);
            check("st_mem_addr", bus.mem_addr, 32'h204);
            check("st_mem_wdata", bus.mem_wdata, 32'h11223344);
            check("st_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'hC);
            check("st_d_ready_wait", {31'b0, bus.d_ready}, 32'd0);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check("st_d_ready", {31'b0, bus.d_ready}, 32'd1);
        check("st_bus_err", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        bus.d_valid   = 1'b0;
        bus.mem_ready = 1'b0;
        check("st_done_busy", {31'b0, busy}, 32'd0);
        check("st_done_mem_valid", {31'b0, bus.mem_valid}, 32'd0);

        // Fresh reset so round-robin starts from last_grant=I, then four held ties
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h40;
        bus.d_valid = 1'b1;
        bus.d_addr  = 32'h80;
        bus.d_wdata = 32'h55AA55AA;
        bus.d_wstrb = 4'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            exp_addr = exp_d ? 32'h80 : 32'h40;
            @(negedge clk);
            check("tie_busy", {31'b0, busy}, 32'd1);
            check("tie_mem_addr", bus.mem_addr, exp_addr);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'h1000 + k;
            #1;
            check("tie_d_ready", {31'b0, bus.d_ready}, {31'b0, exp_d});
            check("tie_i_ready", {31'b0, bus.i_ready}, {31'b0, !exp_d});
            @(negedge clk);
            bus.mem_ready = 1'b0;
            check("tie_idle", {31'b0, busy}, 32'd0);
        end
        bus.d_valid = 1'b0;
        @(negedge clk);
        check("tie_i_addr", bus.mem_addr, 32'h40);
        check("tie_i_wdata", bus.mem_wdata, 32'h0);
        check("tie_i_wstrb", {28'b0, bus.mem_wstrb}, 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE0001;
        #1;
        check("tie_i_ready_last", {31'b0, bus.i_ready}, 32'd1);
        check("tie_i_rdata", bus.i_rdata, 32'hCAFE0001);
        check("tie_d_ready_last", {31'b0, bus.d_ready}, 32'd0);
        @(negedge clk);
        bus.i_valid   = 1'b0;
        bus.mem_ready = 1'b0;

        // Abandon: d_valid drops in the 2nd ISSUE cycle, mem_ready in the 4th
        bus.d_valid = 1'b1;
        bus.d_addr  = 32'h300;
        bus.d_wdata = 32'hA5A5A5A5;
        bus.d_wstrb = 4'hF;
        @(negedge clk);
        check("ab_c1_valid", {31'b0, bus.mem_valid}, 32'd1);
        @(negedge clk);
        bus.d_valid = 1'b0;
        #1;
        check("ab_c2_ready", {31'b0, bus.d_ready}, 32'd0);
        @(negedge clk);
        check("ab_c3_valid", {31'b0, bus.mem_valid}, 32'd1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h77777777;
        #1;
        check("ab_c4_valid", {31'b0, bus.mem_valid}, 32'd1);
        check("ab_c4_addr", bus.mem_addr, 32'h300);
        check("ab_c4_d_ready", {31'b0, bus.d_ready}, 32'd0);
        check("ab_c4_d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("ab_done_busy", {31'b0, busy}, 32'd0);
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h500;
        @(negedge clk);
        check("ab_next_addr", bus.mem_addr, 32'h500);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        #1;
        check("ab_next_i_ready", {31'b0, bus.i_ready}, 32'd1);
        check("ab_next_i_rdata", bus.i_rdata, 32'h0BADF00D);
        @(negedge clk);
        bus.i_valid   = 1'b0;
        bus.mem_ready = 1'b0;

        // Timeout: fifth ISSUE cycle completes with bus_err and zero data
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h600;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("to_wait_ready", {31'b0, bus.i_ready}, 32'd0);
            check("to_wait_err", {31'b0, bus_err}, 32'd0);
        end
        @(negedge clk);
        bus.mem_rdata = 32'hFFFFFFFF;
        #1;
        check("to_i_ready", {31'b0, bus.i_ready}, 32'd1);
        check("to_bus_err", {31'b0, bus_err}, 32'd1);
        check("to_i_rdata", bus.i_rdata, 32'h0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        check("to_after_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("to_after_err", {31'b0, bus_err}, 32'd0);

        // mem_ready on the timeout cycle wins: normal completion
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h604;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
        #1;
        check("to_race_ready", {31'b0, bus.i_ready}, 32'd1);
        check("to_race_err", {31'b0, bus_err}, 32'd0);
        check("to_race_rdata", bus.i_rdata, 32'h12345678);
        @(negedge clk);
        bus.i_valid   = 1'b0;
        bus.mem_ready = 1'b0;

        // Asynchronous reset in mid-ISSUE
        bus.d_valid = 1'b1;
        bus.d_addr  = 32'h800;
        bus.d_wstrb = 4'h0;
        @(negedge clk);
        check("ar_busy_before", {31'b0, busy}, 32'd1);
        bus.mem_ready = 1'b1;
        #1;
        check("ar_d_ready_before", {31'b0, bus.d_ready}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("ar_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("ar_busy", {31'b0, busy}, 32'd0);
        check("ar_ready", {30'b0, bus.i_ready, bus.d_ready}, 32'd0);
        check("ar_mem_addr", bus.mem_addr, 32'h0);
        bus.d_valid   = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h700;
        @(negedge clk);
        check("ar_i_busy", {31'b0, busy}, 32'd1);
        check("ar_i_addr", bus.mem_addr, 32'h700);
        bus.mem_ready = 1'b1;
        #1;
        check("ar_i_ready", {31'b0, bus.i_ready}, 32'd1);
        @(negedge clk);
        bus.i_valid   = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core memory port (valid/ready/addr/rdata/wdata/wstrb) between the instruction-fetch requester (I, read-only) and the execute-stage load/store requester (D).
- Latches the winning request, holds it on the memory port until mem_ready or timeout, then routes the response back to the owner.
- Sits between fetch/execute and the memory/bus; owns the memory-side mem_* signals.

Parameters:
TIMEOUT, 255, ISSUE cycles without mem_ready before a forced error completion; 0 disables the timeout.
CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
i_valid  in  1  fetch request
i_ready  out  1  fetch completion strobe
i_addr  in  32  fetch word address
i_rdata  out  32  fetch read data, valid while i_ready=1
d_valid  in  1  load/store request
d_ready  out  1  load/store completion strobe
d_addr  in  32  load/store word address
d_wdata  in  32  store data
d_wstrb  in  4  byte strobes; 0 = load
d_rdata  out  32  load data, valid while d_ready=1
mem_valid  out  1  memory request
mem_ready  in  1  memory completion
mem_addr  out  32  latched address
mem_wdata  out  32  latched write data
mem_wstrb  out  4  latched strobes
mem_rdata  in  32  memory read data
bus_err  out  1  one-cycle pulse on timeout completion
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, takes effect immediately, no clock edge needed):
  - state=IDLE, owner=I, last_grant=I, abandoned=0, counter=0.
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, bus_err=0.
  - i_ready=d_ready=0, i_rdata=d_rdata=0.
  - Reset in mid-transaction drops mem_valid at once; the memory side must tolerate the abort.
- States: IDLE, ISSUE.
- IDLE:
  - If any request is valid at the clock edge, latch the winner's addr/wdata/wstrb, set owner, last_grant=owner, abandoned=0, counter=0, and go to ISSUE.
  - For an I grant, latch mem_wstrb=0 and mem_wdata=0.
  - Arbitration without ROUND_ROBIN_EN: fixed priority, D beats I.
  - mem_ready seen in IDLE is ignored.
- ISSUE:
  - mem_valid=1 (registered); mem_addr, mem_wdata and mem_wstrb hold the latched values and are stable until completion.
  - Owner ready = ISSUE && mem_ready && owner_valid && !abandoned. This is combinational from mem_ready.
  - Owner rdata = mem_rdata while its ready is 1; otherwise the rdata output holds 0.
  - On mem_ready: return to IDLE.
  - Back-to-back transactions therefore take at least 2 cycles each (one IDLE cycle, one ISSUE cycle).
- Abandon:
  - If owner_valid is 0 in any ISSUE cycle, set abandoned=1; it is sticky until IDLE.
  - An abandoned transaction still completes on the memory side with the latched values; its response is discarded and no ready is raised.
  - This covers the execute stage dropping a request on pipeline flush.
- Timeout (TIMEOUT>0):
  - counter increments each ISSUE cycle with mem_ready=0.
  - When counter==TIMEOUT and mem_ready=0: owner ready=1 (unless abandoned), owner rdata=32'h0, bus_err=1 for that cycle, mem_valid drops next cycle, state goes to IDLE.
  - mem_ready in the same cycle as the timeout takes precedence: normal completion, no bus_err.
  - TIMEOUT=0: the counter is not compared, and a transaction may wait indefinitely.
- Requester contract: valid stays high until its ready pulse. Address and data need only be stable at the edge where the request is latched.
- The ready pulse is exactly one cycle. A requester still valid in the cycle after its ready is treated as a new request.
- busy = (state==ISSUE).

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: when both i_valid and d_valid are high in IDLE, the grant goes to the requester that is not last_grant. last_grant resets to I, so D wins the first tie. A single requester is always granted.
- Undefined: fixed D-over-I priority; last_grant is still updated but unused.

Test Plan:
- Load, single requester: d_valid=1, d_addr=0x100, d_wstrb=0; memory returns mem_ready one cycle after mem_valid with rdata 0xDEADBEEF -> mem_addr=0x100, mem_wstrb=0, d_ready for 1 cycle, d_rdata=0xDEADBEEF, i_ready never high.
- Store: d_addr=0x204, d_wdata=0x11223344, d_wstrb=4'b1100 -> mem_valid with those values held stable over a 3-cycle wait, d_ready once, then state IDLE.
- Tie, fixed priority: i_valid and d_valid rise together, both held -> D served first, then I. With the macro defined, 4 consecutive ties -> grants D, I, D, I.
- Abandon: d_valid drops on the 2nd ISSUE cycle, mem_ready on the 4th -> mem_valid held through the 4th cycle, d_ready stays 0, next grant starts normally.
- Timeout: TIMEOUT=4, mem_ready held 0 -> owner ready and bus_err=1 on the 5th ISSUE cycle (counter==4), rdata=0, mem_valid=0 next cycle.
- Async reset mid-ISSUE: rst=0 between edges -> mem_valid, busy, i_ready and d_ready go to 0 immediately. After rst=1 with i_valid=1 -> I granted on the next edge.
